piso_serializer: RTL
====================

Name: piso_serializer

Overview:
Parametrised parallel-in/serial-out serializer, the successor to the fixed 8-bit shift register. It accepts a DATA_W-bit word over a valid/ready handshake and shifts it out one bit per shift_en strobe, so the bit rate can be set externally. Bit order (LSB- or MSB-first) is chosen per frame. It provides busy/done status and supports back-to-back frames with no idle cycle, and sits between a byte/word source and a serial line driver.

Parameters:
DATA_W, 8, word width in bits; legal range >= 2.
IDLE_LEVEL, 1'b0, ser_out level when no frame is active.
PARITY_ODD, 0, parity sense when PARITY_EN is defined: 0 = even, 1 = odd. Ignored otherwise.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
s_valid  input  1  source presents a word.
s_ready  output  1  block can accept a word this cycle.
s_data  input  DATA_W  word to serialize.
s_msb_first  input  1  bit order, sampled with s_data: 1 = MSB first, 0 = LSB first.
shift_en  input  1  bit-rate strobe; advances to the next bit.
ser_out  output  1  serial data, registered.
ser_valid  output  1  high while ser_out carries a frame bit, registered.
busy  output  1  high whenever the state is not IDLE.
done  output  1  one-cycle pulse after the last bit of a frame has been shifted out.

Behaviour:
- Reset (synchronous, active-high; reset rst, clock clk):
  - state = IDLE, ser_out = IDLE_LEVEL, ser_valid = 0, done = 0, busy = 0.
  - Shift register and counter cleared.
  - Reset mid-frame abandons the frame: no done pulse, and the word is not replayed.
- States: IDLE, SHIFT, plus PARITY when PARITY_EN is defined.
- Internal counter bit_cnt is $clog2(DATA_W) bits wide. last = (bit_cnt == DATA_W-1).
- s_ready is combinational: high in IDLE, or in SHIFT when last && shift_en (PARITY state with shift_en when PARITY_EN is defined).
- Accept = s_valid && s_ready. On the accept edge:
  - Latch s_data and s_msb_first.
  - ser_out = first bit (s_data[0] if LSB-first, s_data[DATA_W-1] if MSB-first).
  - ser_valid = 1, bit_cnt = 0, state = SHIFT.
  - Latency: the first bit is visible in the cycle after the handshake.
- SHIFT, shift_en = 0: hold all state and outputs; the bit is held for any number of cycles.
- SHIFT, shift_en = 1, not last: ser_out = next bit in the latched order, bit_cnt + 1.
- SHIFT, shift_en = 1, last, PARITY_EN not defined:
  - done = 1 for one cycle.
  - If a new word is accepted in the same cycle, load it as above and stay in SHIFT (no gap, ser_valid stays 1).
  - Otherwise: state = IDLE, ser_out = IDLE_LEVEL, ser_valid = 0.
- done is cleared on every other cycle.
- s_valid in IDLE with shift_en irrelevant: accepted immediately.
- While SHIFT and not at the last bit, s_ready = 0; a word held on s_data is not sampled.
- The frame is DATA_W bits long and is fully occupied by data.

Optional Feature:
Macro PIPO_PARITY_EN... correction: the macro is PISO_PARITY_EN.
- Defined:
  - The last data bit with shift_en goes to PARITY instead of finishing the frame.
  - ser_out = ^data XOR PARITY_ODD, ser_valid = 1.
  - The next shift_en in PARITY ends the frame: done pulses, and a back-to-back load is allowed as described for SHIFT.
  - Frame length is DATA_W+1 bits.
- Not defined: the PARITY state, parity logic and PARITY_ODD usage are absent; behaviour is as above.

Decomposition:
- Package piso_pkg holds:
  - state enum (IDLE, SHIFT, PARITY);
  - function cnt_w(DATA_W) returning $clog2(DATA_W);
  - localparam for the state encoding width.
- No sub-module: the counter, shifter and FSM are a single module. Parity is computed inline with a reduction XOR.

Test Plan:
- Reset check: assert rst for 2 cycles mid-frame -> ser_out = IDLE_LEVEL, ser_valid = 0, busy = 0, s_ready = 1, and no done pulse.
- LSB-first, shift_en tied to 1, DATA_W = 8, s_data = 0xC1 -> ser_out 1,0,0,0,0,0,1,1 on cycles 1-8 after the handshake; done pulses on cycle 9; s_ready = 1 on cycle 8.
- MSB-first with the same word 0xC1 -> 1,1,0,0,0,0,0,1.
- shift_en strobing every 4th cycle with 0x5A, LSB-first -> each bit held 4 cycles (0,1,0,1,1,0,1,0); s_ready low until the last strobe.
- Back-to-back: s_valid held high with 0xC1 then 0x0F, shift_en = 1 -> 16 contiguous bits, ser_valid never drops, a single done pulse between frames, second frame LSB-first 1,1,1,1,0,0,0,0.
- PISO_PARITY_EN, PARITY_ODD = 0, s_data = 0x07 -> 8 data bits then parity bit 1, done after bit 9; with 0x03 the parity bit is 0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

  // Width of the state encoding; fits IDLE, SHIFT and PARITY.
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Bit-counter width for a DATA_W-bit word.
  function automatic int cnt_w(input int data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parametrised parallel-in/serial-out serializer with per-frame bit order,
// externally strobed bit rate and back-to-back frame support.
// Optional parity bit appended after the data when PISO_PARITY_EN is defined.
import piso_pkg::*;

module piso_serializer #(
  parameter int   DATA_W     = 8,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_msb_first,
  input  logic              shift_en,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  // Reject illegal parameterisations at elaboration time.
  if (DATA_W < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("piso_serializer: illegal DATA_W or PARITY_ODD");
  end

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] shr_reg, shr_next;     // remaining bits, next one at the edge
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              msb_reg, msb_next;
  logic              ser_out_reg, ser_out_next;
  logic              ser_valid_reg, ser_valid_next;
  logic              done_reg, done_next;
`ifdef PISO_PARITY_EN
  logic              par_reg, par_next;     // parity of the latched word
`endif

  logic last;
  logic accept;

  assign last      = (cnt_reg == LAST_CNT);
  assign accept    = s_valid && s_ready;
  assign ser_out   = ser_out_reg;
  assign ser_valid = ser_valid_reg;
  assign done      = done_reg;
  assign busy      = (state_reg != IDLE);

  // Ready: always in IDLE, otherwise only on the strobe that ends the frame.
  always_comb begin
    s_ready = 1'b0;
    case (state_reg)
      IDLE:   s_ready = 1'b1;
`ifdef PISO_PARITY_EN
      SHIFT:  s_ready = 1'b0;
      PARITY: s_ready = shift_en;
`else
      SHIFT:  s_ready = last && shift_en;
`endif
      default: s_ready = 1'b0;
    endcase
  end

  // Next-state, shifter and output logic; a new word load overrides frame end.
  always_comb begin
    state_next     = state_reg;
    shr_next       = shr_reg;
    cnt_next       = cnt_reg;
    msb_next       = msb_reg;
    ser_out_next   = ser_out_reg;
    ser_valid_next = ser_valid_reg;
    done_next      = 1'b0;
`ifdef PISO_PARITY_EN
    par_next       = par_reg;
`endif

    case (state_reg)
      IDLE: begin
        ser_out_next   = IDLE_LEVEL;
        ser_valid_next = 1'b0;
      end
      SHIFT: begin
        if (shift_en) begin
          if (!last) begin
            ser_out_next = msb_reg ? shr_reg[DATA_W-1] : shr_reg[0];
            shr_next     = msb_reg ? (shr_reg << 1) : (shr_reg >> 1);
            cnt_next     = cnt_reg + 1'b1;
          end else begin
`ifdef PISO_PARITY_EN
            state_next   = PARITY;
            ser_out_next = par_reg ^ (PARITY_ODD != 0);
`else
            state_next     = IDLE;
            done_next      = 1'b1;
            ser_out_next   = IDLE_LEVEL;
            ser_valid_next = 1'b0;
`endif
          end
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (shift_en) begin
          state_next     = IDLE;
          done_next      = 1'b1;
          ser_out_next   = IDLE_LEVEL;
          ser_valid_next = 1'b0;
        end
      end
`endif
      default: begin
        state_next     = IDLE;
        ser_out_next   = IDLE_LEVEL;
        ser_valid_next = 1'b0;
      end
    endcase

    if (accept) begin
      state_next     = SHIFT;
      msb_next       = s_msb_first;
      ser_out_next   = s_msb_first ? s_data[DATA_W-1] : s_data[0];
      shr_next       = s_msb_first ? (s_data << 1) : (s_data >> 1);
      cnt_next       = '0;
      ser_valid_next = 1'b1;
`ifdef PISO_PARITY_EN
      par_next       = ^s_data;
`endif
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      shr_reg       <= '0;
      cnt_reg       <= '0;
      msb_reg       <= 1'b0;
      ser_out_reg   <= IDLE_LEVEL;
      ser_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
`ifdef PISO_PARITY_EN
      par_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      shr_reg       <= shr_next;
      cnt_reg       <= cnt_next;
      msb_reg       <= msb_next;
      ser_out_reg   <= ser_out_next;
      ser_valid_reg <= ser_valid_next;
      done_reg      <= done_next;
`ifdef PISO_PARITY_EN
      par_reg       <= par_next;
`endif
    end
  end

endmodule
